// File: rtl/solve_matrix_fsm_param_if.sv
// Request/acknowledge bundle between solve_matrix_fsm_param (master) and the
// row memory, swapper, divider and multiply-subtract units (slave).
interface solve_matrix_fsm_param_if #(
  parameter int unsigned IDX_W = 3
);
  logic             mem_rd_req;
  logic             mem_rd_ack;
  logic [IDX_W-1:0] mem_rd_row;
  logic [IDX_W-1:0] mem_rd_col;
  logic             mem_rd_zero;

  logic             swap_req;
  logic             swap_ack;
  logic [IDX_W-1:0] swap_row_a;
  logic [IDX_W-1:0] swap_row_b;

  logic             div_req;
  logic             div_done;
  logic [IDX_W-1:0] div_row;
  logic [IDX_W-1:0] div_col;

  logic             elim_req;
  logic             elim_done;
  logic [IDX_W-1:0] elim_src_row;
  logic [IDX_W-1:0] elim_dst_row;
  logic [IDX_W-1:0] elim_col;

  modport master (
    output mem_rd_req, mem_rd_row, mem_rd_col,
    input  mem_rd_ack, mem_rd_zero,
    output swap_req, swap_row_a, swap_row_b,
    input  swap_ack,
    output div_req, div_row, div_col,
    input  div_done,
    output elim_req, elim_src_row, elim_dst_row, elim_col,
    input  elim_done
  );

  modport slave (
    input  mem_rd_req, mem_rd_row, mem_rd_col,
    output mem_rd_ack, mem_rd_zero,
    input  swap_req, swap_row_a, swap_row_b,
    output swap_ack,
    input  div_req, div_row, div_col,
    output div_done,
    input  elim_req, elim_src_row, elim_dst_row, elim_col,
    output elim_done
  );
endinterface

// File: rtl/solve_matrix_fsm_param.sv
// Gauss / Gauss-Jordan elimination sequencer for a ROWS x COLS augmented matrix.
// Define SOLVE_BACK_ELIM_EN to also eliminate rows above the pivot (reduced form).
module solve_matrix_fsm_param #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic                     clk,
  input  logic                     program_reset,
  input  logic                     start_process,
  output logic                     end_process,
  output logic                     singular,
  output logic [IDX_W-1:0]         rank,
  output logic [3:0]               current_state,
  solve_matrix_fsm_param_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_NEXT_PIVOT  = 4'd1,
    S_SEARCH      = 4'd2,
    S_SWAP        = 4'd3,
    S_NORMALIZE   = 4'd4,
    S_ELIM_SELECT = 4'd5,
    S_ELIMINATE   = 4'd6,
    S_DONE        = 4'd7
  } state_e;

  localparam logic [IDX_W-1:0] ROWS_I   = IDX_W'(ROWS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] srch_q, srch_d;
  logic [IDX_W-1:0] tgt_q, tgt_d;
  logic [IDX_W-1:0] rank_q, rank_d;
  logic             singular_q, singular_d;
  logic [IDX_W-1:0] first_tgt;
  logic             rd_req, sw_req, dv_req, el_req, done;

`ifdef SOLVE_BACK_ELIM_EN
  assign first_tgt = '0;
`else
  assign first_tgt = row_q + ONE;
`endif

  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      srch_q     <= '0;
      tgt_q      <= '0;
      rank_q     <= '0;
      singular_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      srch_q     <= srch_d;
      tgt_q      <= tgt_d;
      rank_q     <= rank_d;
      singular_q <= singular_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    srch_d     = srch_q;
    tgt_d      = tgt_q;
    rank_d     = rank_q;
    singular_d = singular_q;
    rd_req     = 1'b0;
    sw_req     = 1'b0;
    dv_req     = 1'b0;
    el_req     = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start_process) begin
          row_d      = '0;
          col_d      = '0;
          rank_d     = '0;
          singular_d = 1'b0;
          state_d    = S_NEXT_PIVOT;
        end
      end
      S_NEXT_PIVOT: begin
        if (row_q == ROWS_I || col_q == LAST_COL) begin
          state_d = S_DONE;
        end else begin
          srch_d  = row_q;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        rd_req = 1'b1;
        if (bus.mem_rd_ack) begin
          if (!bus.mem_rd_zero) begin
            state_d = (srch_q == row_q) ? S_NORMALIZE : S_SWAP;
          end else if (srch_q != LAST_ROW) begin
            srch_d = srch_q + ONE;
          end else begin
            // Whole column is zero below the pivot row: skip it, row stays put.
            singular_d = 1'b1;
            col_d      = col_q + ONE;
            state_d    = S_NEXT_PIVOT;
          end
        end
      end
      S_SWAP: begin
        sw_req = 1'b1;
        if (bus.swap_ack) state_d = S_NORMALIZE;
      end
      S_NORMALIZE: begin
        dv_req = 1'b1;
        if (bus.div_done) begin
          tgt_d   = first_tgt;
          state_d = S_ELIM_SELECT;
        end
      end
      S_ELIM_SELECT: begin
        if (tgt_q == ROWS_I) begin
          rank_d  = rank_q + ONE;
          row_d   = row_q + ONE;
          col_d   = col_q + ONE;
          state_d = S_NEXT_PIVOT;
        end else if (tgt_q == row_q) begin
          tgt_d = tgt_q + ONE;
        end else begin
          state_d = S_ELIMINATE;
        end
      end
      S_ELIMINATE: begin
        el_req = 1'b1;
        if (bus.elim_done) begin
          tgt_d   = tgt_q + ONE;
          state_d = S_ELIM_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_rd_req   = rd_req;
  assign bus.mem_rd_row   = srch_q;
  assign bus.mem_rd_col   = col_q;
  assign bus.swap_req     = sw_req;
  assign bus.swap_row_a   = row_q;
  assign bus.swap_row_b   = srch_q;
  assign bus.div_req      = dv_req;
  assign bus.div_row      = row_q;
  assign bus.div_col      = col_q;
  assign bus.elim_req     = el_req;
  assign bus.elim_src_row = row_q;
  assign bus.elim_dst_row = tgt_q;
  assign bus.elim_col     = col_q;

  assign end_process   = done;
  assign singular      = singular_q;
  assign rank          = rank_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_solve_matrix_fsm_param.sv
// Bench for solve_matrix_fsm_param: zero-pattern memory responder, algorithmic
// model of the expected transaction stream, and directed corner cases.
module tb_solve_matrix_fsm_param;
  localparam int unsigned ROWS  = 3;
  localparam int unsigned COLS  = 4;
  localparam int unsigned IDX_W = 3;
`ifdef SOLVE_BACK_ELIM_EN
  localparam bit BACK      = 1'b1;
  localparam int EXP_ELIMS = 6;
`else
  localparam bit BACK      = 1'b0;
  localparam int EXP_ELIMS = 3;
`endif
  localparam int K_RD = 1, K_SW = 2, K_DV = 3, K_EL = 4;

  logic             clk = 1'b0;
  logic             program_reset;
  logic             start_process;
  logic             end_process;
  logic             singular;
  logic [IDX_W-1:0] rank;
  logic [3:0]       current_state;

  solve_matrix_fsm_param_if #(.IDX_W(IDX_W)) bus ();

  solve_matrix_fsm_param #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .program_reset (program_reset),
    .start_process (start_process),
    .end_process   (end_process),
    .singular      (singular),
    .rank          (rank),
    .current_state (current_state),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] txn(input int k, input int a, input int b, input int c);
    return {k[7:0], a[7:0], b[7:0], c[7:0]};
  endfunction

  function automatic logic [63:0] outs();
    return {23'd0, end_process, singular, rank, current_state,
            bus.mem_rd_req, bus.mem_rd_row, bus.mem_rd_col,
            bus.swap_req, bus.swap_row_a, bus.swap_row_b,
            bus.div_req, bus.div_row, bus.div_col,
            bus.elim_req, bus.elim_src_row, bus.elim_dst_row, bus.elim_col};
  endfunction

  // Zero pattern of the matrix: 1 = entry non-zero.
  bit          nz [ROWS][COLS];
  logic [31:0] exp_q [$];
  int          exp_rank;
  bit          exp_sing;

  task automatic fill_nonzero();
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLS); c++) nz[r][c] = 1'b1;
  endtask

  // Gaussian elimination on the zero pattern, emitting every unit operation.
  task automatic build_model();
    bit m [ROWS][COLS];
    int r, c, piv;
    m = nz;
    r = 0;
    c = 0;
    exp_q.delete();
    exp_rank = 0;
    exp_sing = 1'b0;
    while (r < int'(ROWS) && c < int'(COLS) - 1) begin
      piv = -1;
      for (int s = r; s < int'(ROWS); s++) begin
        exp_q.push_back(txn(K_RD, s, c, 0));
        if (m[s][c]) begin
          piv = s;
          break;
        end
      end
      if (piv < 0) begin
        exp_sing = 1'b1;
        c++;
      end else begin
        if (piv != r) begin
          exp_q.push_back(txn(K_SW, r, piv, 0));
          for (int j = 0; j < int'(COLS); j++) begin
            bit tmp;
            tmp = m[r][j];
            m[r][j] = m[piv][j];
            m[piv][j] = tmp;
          end
        end
        exp_q.push_back(txn(K_DV, r, c, 0));
        for (int t = (BACK ? 0 : r + 1); t < int'(ROWS); t++) begin
          if (t != r) begin
            exp_q.push_back(txn(K_EL, r, t, c));
            m[t][c] = 1'b0;
          end
        end
        exp_rank++;
        r++;
        c++;
      end
    end
  endtask

  // Unit responder: acknowledges after dly idle cycles, applies swap/elim to the pattern.
  bit hold_rd = 0, hold_elim = 0, inj_swap = 0, inj_div = 0, inj_elim = 0;
  int dly = 0, cnt = 0;

  always @(negedge clk) begin
    if ({bus.mem_rd_ack, bus.swap_ack, bus.div_done, bus.elim_done} !== 4'b0) begin
      bus.mem_rd_ack = 1'b0;
      bus.swap_ack   = 1'b0;
      bus.div_done   = 1'b0;
      bus.elim_done  = 1'b0;
      bus.mem_rd_zero = 1'b0;
      cnt = 0;
    end else if (inj_swap || inj_div || inj_elim) begin
      bus.swap_ack  = inj_swap;
      bus.div_done  = inj_div;
      bus.elim_done = inj_elim;
      inj_swap = 0;
      inj_div  = 0;
      inj_elim = 0;
    end else if (bus.mem_rd_req && !hold_rd) begin
      if (cnt >= dly) begin
        bus.mem_rd_zero = !nz[int'(bus.mem_rd_row)][int'(bus.mem_rd_col)];
        bus.mem_rd_ack  = 1'b1;
      end else cnt++;
    end else if (bus.swap_req) begin
      if (cnt >= dly) begin
        for (int j = 0; j < int'(COLS); j++) begin
          bit tmp;
          tmp = nz[int'(bus.swap_row_a)][j];
          nz[int'(bus.swap_row_a)][j] = nz[int'(bus.swap_row_b)][j];
          nz[int'(bus.swap_row_b)][j] = tmp;
        end
        bus.swap_ack = 1'b1;
      end else cnt++;
    end else if (bus.div_req) begin
      if (cnt >= dly) bus.div_done = 1'b1;
      else cnt++;
    end else if (bus.elim_req && !hold_elim) begin
      if (cnt >= dly) begin
        nz[int'(bus.elim_dst_row)][int'(bus.elim_col)] = 1'b0;
        bus.elim_done = 1'b1;
      end else cnt++;
    end else begin
      cnt = 0;
    end
  end

  // Compare process: every active request must be the next expected operation.
  bit          chk_en = 0;
  bit          prev_done = 0;
  int          prev_kind = 0;
  int          ck_kind, ck_nreq;
  logic        ck_ack;
  logic [31:0] ck_act;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      case (prev_kind)
        K_RD:    ck_ack = bus.mem_rd_ack;
        K_SW:    ck_ack = bus.swap_ack;
        K_DV:    ck_ack = bus.div_done;
        K_EL:    ck_ack = bus.elim_done;
        default: ck_ack = 1'b0;
      endcase
      if (ck_ack === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
      ck_nreq = int'(bus.mem_rd_req) + int'(bus.swap_req) + int'(bus.div_req) + int'(bus.elim_req);
      ck_kind = 0;
      ck_act  = '0;
      if (bus.mem_rd_req) begin
        ck_kind = K_RD;
        ck_act  = txn(K_RD, int'(bus.mem_rd_row), int'(bus.mem_rd_col), 0);
      end else if (bus.swap_req) begin
        ck_kind = K_SW;
        ck_act  = txn(K_SW, int'(bus.swap_row_a), int'(bus.swap_row_b), 0);
      end else if (bus.div_req) begin
        ck_kind = K_DV;
        ck_act  = txn(K_DV, int'(bus.div_row), int'(bus.div_col), 0);
      end else if (bus.elim_req) begin
        ck_kind = K_EL;
        ck_act  = txn(K_EL, int'(bus.elim_src_row), int'(bus.elim_dst_row), int'(bus.elim_col));
      end
      if (ck_nreq != 0) begin
        check("one_req", ck_nreq, 1);
        check("txn", ck_act, (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
      end
      if (end_process && !prev_done) begin
        check("done_rank", rank, exp_rank);
        check("done_singular", singular, exp_sing);
        check("done_pending_ops", exp_q.size(), 0);
      end
      prev_kind = ck_kind;
      prev_done = end_process;
    end else begin
      prev_kind = 0;
      prev_done = 1'b0;
    end
  end

  task automatic wait_state(input int s, input int budget);
    for (int i = 0; i < budget && int'(current_state) != s; i++) @(negedge clk);
    check("wait_state", current_state, s);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !end_process; i++) @(negedge clk);
    check("wait_done", end_process, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_process = 1'b1;
    @(negedge clk);
    start_process = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_sw, n_dv, n_el, divrows, idx;
    program_reset = 1'b1;
    start_process = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    @(negedge clk);
    program_reset = 1'b0;
    chk_en = 1'b1;

    // Full-rank matrix, no swaps.
    dly = 1;
    fill_nonzero();
    build_model();
    n_sw = 0; n_dv = 0; n_el = 0; divrows = 0;
    foreach (exp_q[i]) begin
      if (int'(exp_q[i][31:24]) == K_SW) n_sw++;
      if (int'(exp_q[i][31:24]) == K_EL) n_el++;
      if (int'(exp_q[i][31:24]) == K_DV) begin
        n_dv++;
        divrows = (divrows << 4) | int'(exp_q[i][23:16]);
      end
    end
    check("model_t1_swaps", n_sw, 0);
    check("model_t1_divs", n_dv, 3);
    check("model_t1_divrows", divrows, 32'h012);
    check("model_t1_elims", n_el, EXP_ELIMS);
    pulse_start();
    wait_done(400);
    check("t1_rank", rank, 3);
    check("t1_singular", singular, 0);

    // Pivot found in the last row: swap, started as a restart from DONE.
    dly = 0;
    fill_nonzero();
    nz[0][0] = 1'b0;
    nz[1][0] = 1'b0;
    build_model();
    check("model_t2_op0", exp_q[0], txn(K_RD, 0, 0, 0));
    check("model_t2_op1", exp_q[1], txn(K_RD, 1, 0, 0));
    check("model_t2_op2", exp_q[2], txn(K_RD, 2, 0, 0));
    check("model_t2_op3", exp_q[3], txn(K_SW, 0, 2, 0));
    check("model_t2_op4", exp_q[4], txn(K_DV, 0, 0, 0));
    pulse_start();
    check("restart_state", current_state, 1);
    check("restart_end", end_process, 0);
    check("restart_rank", rank, 0);
    check("restart_req", bus.mem_rd_req, 0);
    @(negedge clk);
    check("restart_read", {bus.mem_rd_req, bus.mem_rd_row, bus.mem_rd_col}, 7'b1_000_000);
    wait_done(400);
    check("t2_rank", rank, 3);
    check("t2_singular", singular, 0);

    // All-zero pivot column 1 below row 0: column skipped, rank 2.
    fill_nonzero();
    nz[1][1] = 1'b0;
    nz[2][1] = 1'b0;
    build_model();
    check("model_t3_rank", exp_rank, 2);
    check("model_t3_singular", exp_sing, 1);
    idx = -1;
    foreach (exp_q[i]) if (exp_q[i] == txn(K_RD, 2, 1, 0)) idx = i;
    check("model_t3_next_search", (idx >= 0) ? exp_q[idx + 1] : 32'd0, txn(K_RD, 1, 2, 0));
    pulse_start();
    wait_done(400);
    check("t3_end", end_process, 1);
    check("t3_rank", rank, 2);
    check("t3_singular", singular, 1);

    // Stray start/swap_ack/div_done while a read is pending.
    fill_nonzero();
    build_model();
    hold_rd = 1;
    pulse_start();
    wait_state(2, 10);
    pulse_start();
    @(negedge clk);
    inj_swap = 1;
    inj_div  = 1;
    repeat (3) @(negedge clk);
    check("stray_state", current_state, 2);
    check("stray_addr", {bus.mem_rd_req, bus.mem_rd_row, bus.mem_rd_col}, 7'b1_000_000);
    hold_rd = 0;
    wait_done(400);
    check("t4_rank", rank, 3);

    // Asynchronous reset in the middle of an elimination handshake.
    fill_nonzero();
    build_model();
    hold_elim = 1;
    pulse_start();
    wait_state(6, 40);
    check("pre_reset_elim_req", bus.elim_req, 1);
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    program_reset = 1'b1;
    #1;
    check("async_reset_outputs", outs(), 64'd0);
    @(negedge clk);
    program_reset = 1'b0;
    exp_q.delete();
    hold_elim = 0;
    inj_elim  = 1;
    repeat (3) @(negedge clk);
    check("late_elim_done_ignored", outs(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/solve_matrix_fsm_param.md
# solve_matrix_fsm_param

Parametrised Gauss/Gauss-Jordan elimination controller for an augmented ROWS x COLS matrix held in external row memory. Sequences pivot search, row swap, row normalisation and row elimination through request/acknowledge handshakes to the memory port, swapper, divider and multiply-subtract units. Successor to the fixed-size solve controller: adds generic dimensions, column skipping on all-zero pivot columns with singular/rank reporting, and restart from DONE.

## Interface
- ROWS, 4, matrix rows (≥1)
- COLS, 5, columns including the RHS column (≥2)
- IDX_W, 3, index width; must represent values 0..max(ROWS,COLS)
- clk  in  1  clock, rising edge
- program_reset  in  1  asynchronous, active-high reset
- start_process  in  1  start pulse; sampled only in IDLE or DONE
- end_process  out  1  high while in DONE
- singular  out  1  set when any pivot column is all-zero
- rank  out  IDX_W  pivots found
- mem_rd_req / mem_rd_ack  out/in  1  entry read handshake
- mem_rd_row, mem_rd_col  out  IDX_W  read address
- mem_rd_zero  in  1  read entry is zero; valid with mem_rd_ack
- swap_req / swap_ack  out/in  1  row swap handshake
- swap_row_a, swap_row_b  out  IDX_W  rows to exchange
- div_req / div_done  out/in  1  normalise row by pivot
- div_row, div_col  out  IDX_W  pivot row and column
- elim_req / elim_done  out/in  1  dst -= dst[col] * src
- elim_src_row, elim_dst_row, elim_col  out  IDX_W  elimination operands
- current_state  out  4  state encoding, for debug

## Operation
- Registers: row, col, srch, tgt, rank (IDX_W), singular.
- IDLE(0): on start_process clear row, col, rank, singular -> NEXT_PIVOT.
- NEXT_PIVOT(1): row==ROWS or col==COLS-1 -> DONE; else srch<=row -> SEARCH.
- SEARCH(2): mem_rd_req=1, address (srch,col). On ack:
  - non-zero, srch==row -> NORMALIZE.
  - non-zero, srch!=row -> SWAP.
  - zero, srch<ROWS-1 -> srch++, stay.
  - zero, srch==ROWS-1 -> singular<=1, col++ -> NEXT_PIVOT (row unchanged).
- SWAP(3): swap_req=1, a=row, b=srch; on swap_ack -> NORMALIZE.
- NORMALIZE(4): div_req=1, (row,col); on div_done -> ELIM_SELECT, tgt<=first candidate.
- ELIM_SELECT(5), one cycle per candidate: tgt==row -> tgt++, stay; tgt==ROWS -> rank++, row++, col++ -> NEXT_PIVOT; else -> ELIMINATE.
- ELIMINATE(6): elim_req=1, src=row, dst=tgt, col; on elim_done tgt++ -> ELIM_SELECT.
- DONE(7): end_process=1; start_process restarts as from IDLE.
- Handshakes: req is Moore level, held with operands stable until ack/done; acks are single-cycle pulses; any ack/done while its req is low is ignored. Back-to-back reads allowed: next address on the cycle after ack.
- start_process outside IDLE/DONE ignored.

## Timing
- Reset (async): state IDLE, every output 0, all registers 0; requests drop same cycle as reset assertion, including mid-handshake.
- start sampled at edge N -> NEXT_PIVOT at N+1 -> mem_rd_req high from N+2.
- All req outputs decode from state register only; no combinational path from any ack input to any output.
- Pivot with no swap and no eliminations: SEARCH(ack) -> NORMALIZE -> ELIM_SELECT -> NEXT_PIVOT, plus handshake wait cycles.
- Counters never exceed ROWS/COLS; no wrap-around.

## Configuration
- SOLVE_BACK_ELIM_EN defined: first candidate tgt=0; rows above and below the pivot eliminated (reduced row echelon form).
- Undefined: first candidate tgt=row+1; only rows below eliminated (row echelon form); no elim_dst_row < elim_src_row ever issued.

## Test plan
- ROWS=3, COLS=4, all reads non-zero, ack 1 cycle later -> no swap_req; 3 div_req with div_row 0,1,2; elim_req count 3 (macro off) or 6 (on); end_process=1, rank=3, singular=0.
- Entry (0,0) zero, (1,0) zero, (2,0) non-zero -> reads (0,0),(1,0),(2,0); one swap_req a=0 b=2; then div_req (0,0).
- Column 1 zero in rows 1..2 -> singular=1; next search at (1,2); final rank=2; DONE.
- Reset asserted mid-ELIMINATE with elim_req high -> elim_req and all outputs 0 immediately, current_state=0; later elim_done ignored.
- start_process pulsed during SEARCH -> ignored; pulsed in DONE -> end_process low next cycle, rank/singular cleared, mem_rd_req at (0,0) one cycle later.
- swap_ack and div_done pulsed during SEARCH -> no state change; state advances only on mem_rd_ack.
